vproc_vreg_wr_arb: RTL and testbench
====================================

VPROC_VREG_WR_ARB -- requirements
Module: vproc_vreg_wr_arb

Interface
REQ-001 Parameter PIPE_CNT, default 2: number of pipelines requesting the single vector register file write port; legal range 1..8.
REQ-002 Parameter MAX_VADDR_W, default 5: vreg address width; VADDR_CNT = 1<<MAX_VADDR_W.
REQ-003 Parameter VREG_W, default 128: write data width in bits; byte-enable width VREG_W/8.
REQ-004 Port clk_i, input, 1: the block's one clock; all state updates on its rising edge.
REQ-005 Port sync_rst_ni, input, 1: reset, synchronous and active-low.
REQ-006 Port wr_valid_i, input, [PIPE_CNT]: per-pipe write request.
REQ-007 Port wr_ready_o, output, [PIPE_CNT]: per-pipe grant; a beat transfers when wr_valid_i[i] & wr_ready_o[i].
REQ-008 Port wr_addr_i, input, [PIPE_CNT][MAX_VADDR_W]: per-pipe target vreg.
REQ-009 Port wr_data_i, input, [PIPE_CNT][VREG_W]: per-pipe write data.
REQ-010 Port wr_be_i, input, [PIPE_CNT][VREG_W/8]: per-pipe byte enables.
REQ-011 Port wr_last_i, input, [PIPE_CNT]: beat is the final write of its instruction to wr_addr_i.
REQ-012 Port vreg_wr_en_o, output, 1: registered register-file write enable.
REQ-013 Port vreg_wr_addr_o / vreg_wr_data_o / vreg_wr_be_o, output, MAX_VADDR_W / VREG_W / VREG_W/8: registered write beat.
REQ-014 Port pend_clear_o, output, [PIPE_CNT][VADDR_CNT]: one-hot pending-write clear; row = winning pipe; connects directly to the dispatcher's per-pipe clear input.

Function
REQ-015 At most one bit of wr_ready_o SHALL be set in any cycle; wr_ready_o[i] SHALL only be set while wr_valid_i[i] is set.
REQ-016 wr_ready_o SHALL be combinational from wr_valid_i and internal state; the write port never back-pressures.
REQ-017 FSM states IDLE and LOCKED; LOCKED holds a lock index lk.
REQ-018 In IDLE the grant SHALL go to the first requester at or after round-robin pointer ptr, in ascending index with wrap PIPE_CNT-1 -> 0.
REQ-019 In LOCKED only pipe lk SHALL be granted; the other pipes SHALL receive no grant, even when pipe lk drops valid.
REQ-020 A transferred beat with wr_last_i=0 SHALL move the FSM to LOCKED with lk = winner; a beat with wr_last_i=1 SHALL move it to IDLE and set ptr = (winner+1) mod PIPE_CNT.
REQ-021 ptr SHALL change only on a last beat.
REQ-022 Latency SHALL be one cycle: a beat transferred in cycle N appears on vreg_wr_*_o, with vreg_wr_en_o=1, in cycle N+1.
REQ-023 With no transfer in cycle N, vreg_wr_en_o SHALL be 0 in cycle N+1. Addr, data and be SHALL hold their previous values.
REQ-024 pend_clear_o[w][a] SHALL be 1 in cycle N+1 only when the beat transferred in cycle N was last, came from pipe w and had address a. All other bits SHALL be 0.
REQ-025 This ordering ensures a pending bit never clears before its final data reaches the register file.
REQ-026 A single-beat instruction (last=1 on its only beat) SHALL not enter LOCKED.
REQ-027 With PIPE_CNT=1 the block SHALL degenerate to a registered pass-through with ptr constant 0.

Reset
REQ-028 While sync_rst_ni=0 at a clock edge, the FSM SHALL go to IDLE, ptr and lk to 0, vreg_wr_en_o to 0, addr/data/be to 0, and pend_clear_o to all 0.
REQ-029 wr_ready_o SHALL be 0 while sync_rst_ni=0.
REQ-030 Reset asserted mid-burst (LOCKED) SHALL abandon the lock with no pend_clear_o pulse; recovery of the abandoned pipe is the caller's responsibility.

Structure
REQ-031 The FSM state enum (VREG_WR_ARB_IDLE, VREG_WR_ARB_LOCKED) SHALL be a typedef in vproc_pkg.
REQ-032 Round-robin selection SHALL be a combinational sub-module vproc_rr_pick. Inputs: request vector and pointer. Outputs: one-hot grant and binary index. It is reusable by other arbiters.
REQ-033 The block SHALL contain no memory macros; total state is FSM, ptr, lk and the output register.

Verification
REQ-034 PIPE_CNT=3, reset, then all three valid with last=1 for 3 cycles -> grants 0,1,2 in order; vreg_wr_en_o=1 in cycles 2..4.
REQ-035 Pipe 1 sends 4 beats to addr 5 (last only on beat 4) while pipe 0 requests continuously -> pipe 0 gets no grant during the burst; pend_clear_o[1][5]=1 exactly once, in the cycle after beat 4; pipe 0 is granted next.
REQ-036 Pipe 2 sends beat 1 (last=0), drops valid for 2 cycles, then sends beat 2 (last=1) while pipes 0 and 1 request -> no grants during the gap; vreg_wr_en_o=0 during the gap.
REQ-037 Pipe 0 beat to addr 3, data 0xAA.., be all-ones in cycle N -> vreg_wr_addr_o=3, data 0xAA.., en=1 in N+1; en=0 in N+2 when idle.
REQ-038 sync_rst_ni=0 for 1 cycle in LOCKED on pipe 1 -> all outputs 0, pend_clear_o all 0; pipe 0 is granted first after reset release.

Source files
------------

// File: rtl/vproc_pkg.sv
// ----------------------------------------------------------------------------
// vproc_pkg
// Shared types and helpers for the vector processor write-side arbitration.
//   vreg_wr_arb_state_e : state of the vreg write-port arbiter FSM
//   rr_wrap_inc()       : round-robin pointer increment with wrap at cnt-1 -> 0
// ----------------------------------------------------------------------------
package vproc_pkg;

    typedef enum logic [0:0] {
        VREG_WR_ARB_IDLE   = 1'b0,
        VREG_WR_ARB_LOCKED = 1'b1
    } vreg_wr_arb_state_e;

    // Next round-robin position after idx in a ring of cnt entries.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                                input int unsigned cnt);
        int unsigned nxt;
        nxt = idx + 32'd1;
        return (nxt >= cnt) ? 32'd0 : nxt;
    endfunction

endpackage

// File: rtl/vproc_rr_pick.sv
// ----------------------------------------------------------------------------
// vproc_rr_pick
// Combinational round-robin selector: grants the first requester at or after
// ptr_i, scanning upward and wrapping N-1 -> 0.
//   req_i [N]     : request vector
//   ptr_i [IDX_W] : highest-priority index (must be < N)
//   gnt_o [N]     : one-hot grant, all zero when nothing requests
//   idx_o [IDX_W] : binary index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module vproc_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic        w_found;
    int unsigned w_cand;

    // Scan candidates in priority order; the inner loop keeps every bit
    // select a constant index after unrolling.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_cand  = 32'd0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = ((32'(ptr_i) + k) >= N) ? (32'(ptr_i) + k - N)
                                             : (32'(ptr_i) + k);
            for (int unsigned j = 0; j < N; j++) begin
                if (!w_found && req_i[j] && (j == w_cand)) begin
                    gnt_o[j] = 1'b1;
                    idx_o    = IDX_W'(j);
                    w_found  = 1'b1;
                end else begin
                    w_found  = w_found;
                end
            end
        end
    end

endmodule

// File: rtl/vproc_vreg_wr_arb.sv
// ----------------------------------------------------------------------------
// vproc_vreg_wr_arb
// Arbitrates PIPE_CNT pipelines onto the single vector register file write
// port. Multi-beat instructions hold the port (LOCKED) until their last beat;
// between instructions the grant rotates round-robin. The winning beat is
// registered onto the write port one cycle later, together with a one-hot
// pending-write clear that fires only for last beats, so a pending bit never
// drops before its final data has been written.
//   clk_i, sync_rst_ni          : clock, synchronous active-low reset
//   wr_valid_i / wr_ready_o     : per-pipe request / grant (grant is comb.)
//   wr_addr_i/data_i/be_i/last_i: per-pipe write beat
//   vreg_wr_en/addr/data/be_o   : registered register-file write beat
//   pend_clear_o                : registered [pipe][vreg] pending clear pulse
// ----------------------------------------------------------------------------
module vproc_vreg_wr_arb
    import vproc_pkg::*;
#(
    parameter  int unsigned PIPE_CNT    = 2,
    parameter  int unsigned MAX_VADDR_W = 5,
    parameter  int unsigned VREG_W      = 128,
    localparam int unsigned VADDR_CNT   = 1 << MAX_VADDR_W
) (
    input  logic                                   clk_i,
    input  logic                                   sync_rst_ni,
    input  logic [PIPE_CNT-1:0]                    wr_valid_i,
    output logic [PIPE_CNT-1:0]                    wr_ready_o,
    input  logic [PIPE_CNT-1:0][MAX_VADDR_W-1:0]   wr_addr_i,
    input  logic [PIPE_CNT-1:0][VREG_W-1:0]        wr_data_i,
    input  logic [PIPE_CNT-1:0][VREG_W/8-1:0]      wr_be_i,
    input  logic [PIPE_CNT-1:0]                    wr_last_i,
    output logic                                   vreg_wr_en_o,
    output logic [MAX_VADDR_W-1:0]                 vreg_wr_addr_o,
    output logic [VREG_W-1:0]                      vreg_wr_data_o,
    output logic [VREG_W/8-1:0]                    vreg_wr_be_o,
    output logic [PIPE_CNT-1:0][VADDR_CNT-1:0]     pend_clear_o
);

    // A single pipe still needs a 1-bit index to select its (only) entry.
    localparam int unsigned IDX_W = (PIPE_CNT > 1) ? $clog2(PIPE_CNT) : 1;

    vreg_wr_arb_state_e                 r_state;
    logic [IDX_W-1:0]                   r_ptr;
    logic [IDX_W-1:0]                   r_lk;
    logic                               r_wr_en;
    logic [MAX_VADDR_W-1:0]             r_wr_addr;
    logic [VREG_W-1:0]                  r_wr_data;
    logic [VREG_W/8-1:0]                r_wr_be;
    logic [PIPE_CNT-1:0][VADDR_CNT-1:0] r_pend_clear;

    logic [PIPE_CNT-1:0]                w_pick_gnt;
    logic [IDX_W-1:0]                   w_pick_idx;
    logic [PIPE_CNT-1:0]                w_ready;
    logic [IDX_W-1:0]                   w_win_idx;
    logic                               w_xfer;

    vproc_rr_pick #(
        .N     (PIPE_CNT),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (wr_valid_i),
        .ptr_i (r_ptr),
        .gnt_o (w_pick_gnt),
        .idx_o (w_pick_idx)
    );

    // Grant generation: only the locked pipe may proceed while LOCKED, even
    // if it has dropped valid; nothing is granted during reset.
    always_comb begin
        w_ready   = '0;
        w_win_idx = w_pick_idx;
        if (!sync_rst_ni) begin
            w_ready = '0;
        end else if (r_state == VREG_WR_ARB_LOCKED) begin
            w_ready[r_lk] = wr_valid_i[r_lk];
            w_win_idx     = r_lk;
        end else begin
            w_ready = w_pick_gnt;
        end
    end

    assign w_xfer = |w_ready;

    // Arbiter FSM plus the registered write beat and pending-clear pulse.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_state      <= VREG_WR_ARB_IDLE;
            r_ptr        <= '0;
            r_lk         <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_be      <= '0;
            r_pend_clear <= '0;
        end else begin
            r_wr_en      <= w_xfer;
            r_pend_clear <= '0;
            if (w_xfer) begin
                r_wr_addr <= wr_addr_i[w_win_idx];
                r_wr_data <= wr_data_i[w_win_idx];
                r_wr_be   <= wr_be_i[w_win_idx];
                case (wr_last_i[w_win_idx])
                    1'b1: begin
                        r_state <= VREG_WR_ARB_IDLE;
                        r_ptr   <= IDX_W'(rr_wrap_inc(32'(w_win_idx), PIPE_CNT));
                        r_pend_clear[w_win_idx][wr_addr_i[w_win_idx]] <= 1'b1;
                    end
                    1'b0: begin
                        r_state <= VREG_WR_ARB_LOCKED;
                        r_lk    <= w_win_idx;
                    end
                    default: begin
                        r_state <= VREG_WR_ARB_IDLE;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign wr_ready_o     = w_ready;
    assign vreg_wr_en_o   = r_wr_en;
    assign vreg_wr_addr_o = r_wr_addr;
    assign vreg_wr_data_o = r_wr_data;
    assign vreg_wr_be_o   = r_wr_be;
    assign pend_clear_o   = r_pend_clear;

endmodule

// File: tb/tb_vproc_vreg_wr_arb.sv
// ----------------------------------------------------------------------------
// tb_vproc_vreg_wr_arb
// Directed bench for vproc_vreg_wr_arb with PIPE_CNT=3, MAX_VADDR_W=5,
// VREG_W=128. Grants are sampled on the falling edge; registered outputs are
// sampled 1 time unit after the rising edge that captured the beat.
// ----------------------------------------------------------------------------
module tb_vproc_vreg_wr_arb;

    localparam int unsigned PC = 3;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 128;

    logic                    clk;
    logic                    rst_n;
    logic [PC-1:0]           wr_valid;
    logic [PC-1:0]           wr_ready;
    logic [PC-1:0][AW-1:0]   wr_addr;
    logic [PC-1:0][DW-1:0]   wr_data;
    logic [PC-1:0][DW/8-1:0] wr_be;
    logic [PC-1:0]           wr_last;
    logic                    vreg_wr_en;
    logic [AW-1:0]           vreg_wr_addr;
    logic [DW-1:0]           vreg_wr_data;
    logic [DW/8-1:0]         vreg_wr_be;
    logic [PC-1:0][31:0]     pend_clear;

    int n_cmp;
    int n_err;

    vproc_vreg_wr_arb #(
        .PIPE_CNT    (PC),
        .MAX_VADDR_W (AW),
        .VREG_W      (DW)
    ) dut (
        .clk_i          (clk),
        .sync_rst_ni    (rst_n),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .wr_be_i        (wr_be),
        .wr_last_i      (wr_last),
        .vreg_wr_en_o   (vreg_wr_en),
        .vreg_wr_addr_o (vreg_wr_addr),
        .vreg_wr_data_o (vreg_wr_data),
        .vreg_wr_be_o   (vreg_wr_be),
        .pend_clear_o   (pend_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] pc_bit(input int w, input int a);
        logic [95:0] v;
        v = '0;
        v[w*32 + a] = 1'b1;
        return v;
    endfunction

    task automatic set_pipe(input int p, input logic v, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW/8-1:0] b,
                            input logic l);
        wr_valid[p] = v;
        wr_addr[p]  = a;
        wr_data[p]  = d;
        wr_be[p]    = b;
        wr_last[p]  = l;
    endtask

    // Check the combinational grant mid-cycle, then advance past the edge.
    task automatic rdy_step(input string tag, input logic [PC-1:0] exp);
        @(negedge clk);
        chk_eq(tag, 128'(wr_ready), 128'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic en,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [95:0] pc);
        chk_eq({tag, "_en"},   128'(vreg_wr_en),   128'(en));
        chk_eq({tag, "_addr"}, 128'(vreg_wr_addr), 128'(a));
        chk_eq({tag, "_data"}, vreg_wr_data,       d);
        chk_eq({tag, "_pend"}, 128'(pend_clear),   128'(pc));
    endtask

    logic [DW-1:0] d_aa;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        d_aa     = {16{8'hAA}};
        rst_n    = 1'b0;
        wr_valid = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_be    = '0;
        wr_last  = '0;

        // Reset with every pipe requesting: no grant, all outputs zero.
        set_pipe(0, 1'b1, 5'd10, 128'h10, 16'hFFFF, 1'b1);
        set_pipe(1, 1'b1, 5'd11, 128'h11, 16'hFFFF, 1'b1);
        set_pipe(2, 1'b1, 5'd12, 128'h12, 16'hFFFF, 1'b1);
        rdy_step("rst_rdy", 3'b000);
        @(posedge clk);
        #1;
        chk_out("rst", 1'b0, 5'd0, 128'h0, 96'd0);
        chk_eq("rst_be", 128'(vreg_wr_be), 128'd0);

        // Three single-beat requesters: round-robin 0,1,2.
        rst_n = 1'b1;
        rdy_step("rr0_rdy", 3'b001);
        chk_out("rr0", 1'b1, 5'd10, 128'h10, pc_bit(0, 10));
        rdy_step("rr1_rdy", 3'b010);
        chk_out("rr1", 1'b1, 5'd11, 128'h11, pc_bit(1, 11));
        rdy_step("rr2_rdy", 3'b100);
        chk_out("rr2", 1'b1, 5'd12, 128'h12, pc_bit(2, 12));
        wr_valid = '0;
        rdy_step("idle_rdy", 3'b000);
        chk_out("idle", 1'b0, 5'd12, 128'h12, 96'd0);

        // Pipe 1 four-beat burst to vreg 5 while pipe 0 keeps requesting.
        set_pipe(1, 1'b1, 5'd5, 128'h51, 16'h00FF, 1'b0);
        rdy_step("b1_rdy", 3'b010);
        chk_out("b1", 1'b1, 5'd5, 128'h51, 96'd0);
        chk_eq("b1_be", 128'(vreg_wr_be), 128'(16'h00FF));
        set_pipe(0, 1'b1, 5'd3, d_aa, 16'hFFFF, 1'b1);
        set_pipe(1, 1'b1, 5'd5, 128'h52, 16'h00FF, 1'b0);
        rdy_step("b2_rdy", 3'b010);
        chk_out("b2", 1'b1, 5'd5, 128'h52, 96'd0);
        set_pipe(1, 1'b1, 5'd5, 128'h53, 16'h00FF, 1'b0);
        rdy_step("b3_rdy", 3'b010);
        chk_out("b3", 1'b1, 5'd5, 128'h53, 96'd0);
        set_pipe(1, 1'b1, 5'd5, 128'h54, 16'h00FF, 1'b1);
        rdy_step("b4_rdy", 3'b010);
        chk_out("b4", 1'b1, 5'd5, 128'h54, pc_bit(1, 5));

        // Pipe 0 granted next: addr 3, data AA.., full byte enables.
        wr_valid[1] = 1'b0;
        rdy_step("p0_rdy", 3'b001);
        chk_out("p0", 1'b1, 5'd3, d_aa, pc_bit(0, 3));
        chk_eq("p0_be", 128'(vreg_wr_be), 128'(16'hFFFF));
        wr_valid = '0;
        rdy_step("p0i_rdy", 3'b000);
        chk_out("p0i", 1'b0, 5'd3, d_aa, 96'd0);

        // Pipe 2 locks, drops valid for two cycles while 0 and 1 request.
        set_pipe(2, 1'b1, 5'd7, 128'h71, 16'hFFFF, 1'b0);
        rdy_step("g1_rdy", 3'b100);
        chk_out("g1", 1'b1, 5'd7, 128'h71, 96'd0);
        set_pipe(2, 1'b0, 5'd7, 128'h71, 16'hFFFF, 1'b0);
        set_pipe(0, 1'b1, 5'd1, 128'h01, 16'hFFFF, 1'b1);
        set_pipe(1, 1'b1, 5'd2, 128'h02, 16'hFFFF, 1'b0);
        rdy_step("gap1_rdy", 3'b000);
        chk_out("gap1", 1'b0, 5'd7, 128'h71, 96'd0);
        rdy_step("gap2_rdy", 3'b000);
        chk_out("gap2", 1'b0, 5'd7, 128'h71, 96'd0);
        set_pipe(2, 1'b1, 5'd7, 128'h72, 16'hFFFF, 1'b1);
        rdy_step("g2_rdy", 3'b100);
        chk_out("g2", 1'b1, 5'd7, 128'h72, pc_bit(2, 7));

        // Pointer wrapped to 0; then pipe 1 starts a burst and locks.
        wr_valid[2] = 1'b0;
        rdy_step("w0_rdy", 3'b001);
        chk_out("w0", 1'b1, 5'd1, 128'h01, pc_bit(0, 1));
        rdy_step("l1_rdy", 3'b010);
        chk_out("l1", 1'b1, 5'd2, 128'h02, 96'd0);

        // One-cycle reset while locked on pipe 1.
        rst_n = 1'b0;
        rdy_step("rl_rdy", 3'b000);
        chk_out("rl", 1'b0, 5'd0, 128'h0, 96'd0);
        chk_eq("rl_be", 128'(vreg_wr_be), 128'd0);
        rst_n = 1'b1;
        rdy_step("post_rdy", 3'b001);
        chk_out("post", 1'b1, 5'd1, 128'h01, pc_bit(0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
